// File: rtl/cic_comp_pkg.sv
// Shared constants, coefficient table and FSM state type for the CIC
// droop-compensation FIR.
package cic_comp_pkg;

  localparam int unsigned WIN   = 10;
  localparam int unsigned WOUT  = 10;
  localparam int unsigned ACCW  = 20;
  localparam int unsigned CW    = 9;
  localparam int unsigned KW    = 4;
  localparam int unsigned NTAPS = 11;
  localparam int unsigned SHIFT = 7;

  localparam int OUT_MAX = 511;
  localparam int OUT_MIN = -512;

  // Q7 taps: sum is 128 (unity DC gain), alternating side lobes lift the band edge
  localparam logic signed [CW-1:0] COEF [NTAPS] = '{
    -9'sd1, 9'sd2, -9'sd3, 9'sd6, -9'sd11, 9'sd142,
    -9'sd11, 9'sd6, -9'sd3, 9'sd2, -9'sd1
  };

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_e;

endpackage

// File: rtl/cic_comp_fir_if.sv
// Sample-in / filtered-sample-out bundle between the CIC and the compensator.
interface cic_comp_fir_if;
  import cic_comp_pkg::*;

  logic signed [WIN-1:0]  x_in;
  logic                   x_valid;
  logic signed [WOUT-1:0] y_out;
  logic                   y_valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    output x_in, x_valid,
    input  y_out, y_valid, busy, overrun
  );

  modport slave (
    input  x_in, x_valid,
    output y_out, y_valid, busy, overrun
  );

endinterface

// File: rtl/cic_comp_coef_rom.sv
// Combinational tap lookup; indices past the last tap read as zero.
module cic_comp_coef_rom
  import cic_comp_pkg::*;
(
  input  logic [KW-1:0]        k,
  output logic signed [CW-1:0] h
);

  always_comb begin
    h = '0;
    case (k)
      4'd0:    h = COEF[0];
      4'd1:    h = COEF[1];
      4'd2:    h = COEF[2];
      4'd3:    h = COEF[3];
      4'd4:    h = COEF[4];
      4'd5:    h = COEF[5];
      4'd6:    h = COEF[6];
      4'd7:    h = COEF[7];
      4'd8:    h = COEF[8];
      4'd9:    h = COEF[9];
      4'd10:   h = COEF[10];
      default: h = '0;
    endcase
  end

endmodule

// File: rtl/cic_comp_fir.sv
// 11-tap CIC droop-compensation FIR with one time-multiplexed MAC, producing
// a rounded, saturated output 12 cycles after each input strobe.
module cic_comp_fir
  import cic_comp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  cic_comp_fir_if.slave    bus
);

  localparam int unsigned PW = CW + WIN;

  state_e                 state;
  state_e                 state_nxt;
  logic [KW-1:0]          k;
  logic signed [ACCW-1:0] acc;
  logic signed [WIN-1:0]  d [NTAPS];
  logic signed [CW-1:0]   coef;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] rnd;
  logic signed [ACCW-1:0] rsh;
  logic signed [WOUT-1:0] sat;
  logic                   load;
  logic                   mac_step;
  logic                   emit;

  cic_comp_coef_rom u_rom (
    .k (k),
    .h (coef)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    mac_step  = 1'b0;
    emit      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.x_valid) begin
          load      = 1'b1;
          state_nxt = MAC;
        end
      end
      MAC: begin
        mac_step = 1'b1;
        if (k == KW'(NTAPS - 1)) state_nxt = OUT;
      end
      OUT: begin
        emit      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Full-precision product, then round half up and clip to the output range
  always_comb begin
    prod = coef * d[k];
    rnd  = acc + ACCW'(64);
    rsh  = rnd >>> SHIFT;
    if (rsh > $signed(ACCW'(OUT_MAX)))      sat = WOUT'(OUT_MAX);
    else if (rsh < $signed(ACCW'(OUT_MIN))) sat = WOUT'(OUT_MIN);
    else                                    sat = WOUT'(rsh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k           <= '0;
      acc         <= '0;
      bus.y_out   <= '0;
      bus.y_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
      for (int i = 0; i < int'(NTAPS); i++) d[i] <= '0;
    end else begin
      bus.y_valid <= emit;
      bus.busy    <= (state_nxt != IDLE);
      // A strobe that lands mid-computation is dropped and latched as an error
      if (bus.x_valid && state != IDLE) bus.overrun <= 1'b1;
      if (load) begin
        for (int i = int'(NTAPS) - 1; i > 0; i--) d[i] <= d[i-1];
        d[0] <= bus.x_in;
        acc  <= '0;
        k    <= '0;
      end
      if (mac_step) begin
        acc <= acc + ACCW'(prod);
        k   <= k + KW'(1);
      end
      if (emit) bus.y_out <= sat;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed-vector bench for cic_comp_fir: impulse, DC step, saturation,
// rounding, overrun and mid-computation reset.
module tb_cic_comp_fir;
  import cic_comp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  cic_comp_fir_if bus ();

  cic_comp_fir dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reset is held alongside a strobe so the strobe must be discarded
  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    bus.x_valid = 1'b1;
    bus.x_in    = 10'sd77;
    repeat (2) @(negedge clk);
    reset       = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_in    = '0;
    check("rst_y_out",   int'(bus.y_out), 0);
    check("rst_y_valid", int'(bus.y_valid), 0);
    check("rst_busy",    int'(bus.busy), 0);
    check("rst_overrun", int'(bus.overrun), 0);
  endtask

  // One strobe, wait for the result, then pad to the CIC's 32-cycle spacing
  task automatic send(input string tag, input int x, input int exp, input bit chk);
    int lat;
    bit seen;
    @(negedge clk);
    bus.x_in    = WIN'(x);
    bus.x_valid = 1'b1;
    @(negedge clk);
    bus.x_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.y_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
    end else if (chk) begin
      check({tag, "_lat"}, lat, 12);
      check(tag, int'(bus.y_out), exp);
    end
    @(negedge clk);
    if (chk) check({tag, "_vld_drop"}, int'(bus.y_valid), 0);
    repeat (32 - 15 - 1) @(negedge clk);
  endtask

  int imp_exp [12] = '{-2, 4, -6, 12, -22, 284, -22, 12, -6, 4, -2, 0};
  int rnd_exp [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
  int dc_exp  [13] = '{-1, 1, -2, 3, -5, 105, 97, 102, 99, 101, 100, 100, 100};

  initial begin
    int vcount;
    int vfirst;
    reset       = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_in    = '0;

    do_reset();

    for (int i = 0; i < 12; i++)
      send($sformatf("imp%0d", i), (i == 0) ? 256 : 0, imp_exp[i], 1'b1);

    do_reset();
    for (int i = 0; i < 11; i++)
      send($sformatf("rnd%0d", i), (i == 0) ? 1 : 0, rnd_exp[i], 1'b1);

    do_reset();
    for (int i = 0; i < 13; i++)
      send($sformatf("dc%0d", i), 100, dc_exp[i], 1'b1);

    // Newest +511 drives the result to the negative rail and vice versa
    do_reset();
    for (int i = 0; i < 14; i++)
      send($sformatf("sat%0d", i), (i % 2 == 0) ? 511 : -512,
           (i % 2 == 0) ? -512 : 511, i >= 10);
    check("sat_overrun", int'(bus.overrun), 0);

    // Second strobe 5 cycles after the first must be dropped
    do_reset();
    vcount = 0;
    vfirst = -1;
    @(negedge clk);
    bus.x_in    = 10'sd100;
    bus.x_valid = 1'b1;
    @(negedge clk);
    bus.x_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.y_valid) begin
        vcount++;
        if (vfirst < 0) vfirst = c;
      end
      if (c == 4) begin
        bus.x_in    = 10'sd200;
        bus.x_valid = 1'b1;
      end else begin
        bus.x_valid = 1'b0;
      end
    end
    check("ovr_count",   vcount, 1);
    check("ovr_latency", vfirst, 12);
    check("ovr_y_out",   int'(bus.y_out), -1);
    check("ovr_flag",    int'(bus.overrun), 1);
    send("ovr_line", 0, 2, 1'b1);
    check("ovr_sticky",  int'(bus.overrun), 1);

    // Reset sampled at E6 aborts the computation and clears the line
    @(negedge clk);
    bus.x_in    = 10'sd300;
    bus.x_valid = 1'b1;
    @(negedge clk);
    bus.x_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    vcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.y_valid) vcount++;
    end
    check("mid_rst_no_valid", vcount, 0);
    check("mid_rst_y_out",    int'(bus.y_out), 0);
    check("mid_rst_busy",     int'(bus.busy), 0);
    check("mid_rst_overrun",  int'(bus.overrun), 0);
    send("mid_rst_next", 0, 0, 1'b1);
    send("mid_rst_next2", 64, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Decimated-rate CIC droop-compensation FIR that sits directly downstream of the 3-stage, R=32 CIC decimator. It consumes the CIC's 10-bit output and its one-cycle sample strobe. It runs an 11-tap symmetric FIR with a single time-multiplexed multiplier-accumulator, using the 32 fast-clock cycles available between decimated samples. It emits a rounded, saturated 10-bit result with a one-cycle valid strobe.

## Interface
- WIN, 10, input sample width (signed two's complement)
- WOUT, 10, output sample width (signed two's complement)
- ACCW, 20, accumulator width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- x_in  in  WIN  signed sample from the CIC (y_out)
- x_valid  in  1  one-cycle strobe, connected to the CIC clk2
- y_out  out  WOUT  filtered sample, held between strobes
- y_valid  out  1  one-cycle strobe, high when y_out is new
- busy  out  1  high while a sample is being processed
- overrun  out  1  sticky flag, set when x_valid arrives while busy

## Operation
- Coefficients are fixed 9-bit signed Q7, h[0..10] = -1, 2, -3, 6, -11, 142, -11, 6, -3, 2, -1.
  - Sum = 128, so DC gain = 1.
  - Alternating side lobes give the high-frequency boost.
- Delay line d[0..10], each WIN bits; d[0] is the newest sample.
- FSM states: IDLE, MAC, OUT.
- IDLE with x_valid=1:
  - shift d[k] <= d[k-1], d[0] <= x_in;
  - acc <= 0, k <= 0;
  - go to MAC.
- MAC:
  - acc <= acc + h[k]*d[k], using a full-precision signed product sign-extended to ACCW;
  - k increments; after k=10 go to OUT.
- OUT:
  - r = (acc + 64) >>> 7 (arithmetic shift, round half up);
  - saturate r to [-512, 511], then y_out <= r;
  - y_valid <= 1; go to IDLE.
- busy = 1 in MAC and OUT.
- x_valid while busy:
  - the sample is dropped and the delay line is untouched;
  - overrun <= 1, which only reset clears;
  - the current computation completes normally.
- Reset values:
  - state IDLE, k=0, acc=0, all d[k]=0;
  - y_out=0, y_valid=0, busy=0, overrun=0.
- reset and x_valid high in the same cycle: reset wins and the sample is discarded.
- Reset mid-MAC/OUT: the computation is aborted and no y_valid is produced.
- Maximum |acc| = 188*512 = 96256, which fits ACCW=20 with no accumulator overflow possible.

## Timing
- Edge E0 samples x_valid=1 and performs the shift.
- Edges E1..E11 perform taps k=0..10.
- Edge E12 registers y_out and sets y_valid=1; edge E13 clears y_valid.
- Latency is 12 cycles from the x_valid sampling edge to y_valid assertion.
- busy is high from after E0 until after E12, i.e. 12 cycles.
- Minimum x_valid spacing is 13 cycles.
  - The CIC spacing of 32 gives 19 idle cycles per sample.
- y_out changes only at the OUT edge and is stable otherwise.
- y_valid is never high on two consecutive cycles.

## Structure
- Package cic_comp_pkg holds:
  - NTAPS=11, COEF array, SHIFT=7;
  - OUT_MAX=511, OUT_MIN=-512;
  - the state enum {IDLE, MAC, OUT}.
- Sub-module cic_comp_coef_rom is a combinational lookup from k (4 bits) to h[k] (9-bit signed); indices 11..15 return 0.
- The top level contains the FSM, delay line, MAC and round/saturate logic.

## Test plan
- Impulse: x=256 once, then zeros every 32 cycles. Successive y_out must be -2, 4, -6, 12, -22, 284, -22, 12, -6, 4, -2, then 0.
- DC: constant x=100 every 32 cycles. From the 11th output onward y_out=100; earlier outputs follow the partial-sum step response.
- Saturation: alternating x = +511, -512 every 32 cycles. Once the line is full, y_out alternates between 511 and -512 (clipped) and overrun stays 0.
- Rounding: a single x=1 impulse yields y_out = 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0.
- Overrun: two x_valid pulses 5 cycles apart. Exactly one y_valid occurs, 12 cycles after the first pulse; overrun=1 afterward; the delay line holds only the first sample.
- Reset mid-MAC: assert reset at E6. No y_valid is produced, all outputs read 0, and the next strobe computes from a zeroed delay line.
